// File: rtl/huffman_ctrl_pkg.sv
// Shared types and sizing for the Huffman decoder front-end controller.
// Holds the controller state encoding and symbol buffer geometry.
package huffman_ctrl_pkg;

    localparam int SYM_WIDTH   = 5;
    localparam int FIFO_DEPTH  = 4;
    localparam int COUNT_WIDTH = 16;
    localparam int FIFO_CW     = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(
        input logic [COUNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/huffman_sym_fifo.sv
// Small first-word-fall-through buffer for decoded symbols.
// A push into a full buffer succeeds only when a pop frees a slot that cycle.
module huffman_sym_fifo
    import huffman_ctrl_pkg::*;
#(
    parameter int WIDTH = SYM_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    assign data_o  = mem[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/huffman_ctrl.sv
// Feeds job bytes MSB-first to a serial Huffman decoder and buffers the
// symbols it returns; bits are throttled so the buffer never loses a symbol.
module huffman_ctrl
    import huffman_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [7:0]             nbytes_i,
    input  logic                   byte_valid_i,
    input  logic [DATA_WIDTH-1:0]  byte_i,
    output logic                   byte_ready_o,
    output logic                   dec_serial_o,
    output logic                   dec_bit_valid_o,
    input  logic                   dec_ready_i,
    input  logic                   dec_valid_i,
    input  logic [SYM_WIDTH-1:0]   dec_symbol_i,
    output logic                   sym_valid_o,
    output logic [SYM_WIDTH-1:0]   sym_o,
    input  logic                   sym_ready_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [COUNT_WIDTH-1:0] sym_count_o,
    output logic                   overflow_o
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int IW = $clog2(DRAIN_CYCLES + 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [7:0]             bytes_left_q;
    logic [DATA_WIDTH-1:0]  shreg_q;
    logic [BW-1:0]          bitcnt_q;
    logic [IW-1:0]          idle_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   ovf_q;

    logic                   ready_raw;
    logic                   bit_valid_raw;
    logic                   done_raw;
    logic                   byte_xfer;
    logic                   consume;
    logic                   last_bit;
    logic                   start_ok;
    logic                   pop;
    logic                   drop;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_CW-1:0]     fifo_count;
    logic [SYM_WIDTH-1:0]   fifo_head;

    assign byte_xfer = byte_ready_o && byte_valid_i;
    assign consume   = dec_bit_valid_o && dec_ready_i;
    assign last_bit  = consume && (bitcnt_q == '0);
    assign start_ok  = (state_q == IDLE) && start_i;
    assign pop       = sym_valid_o && sym_ready_i;
    assign drop      = dec_valid_i && fifo_full && !pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ready_raw     = 1'b0;
        bit_valid_raw = 1'b0;
        done_raw      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (nbytes_i == 8'd0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                ready_raw = 1'b1;
                if (byte_valid_i) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // two free slots cover a symbol already in flight
                bit_valid_raw =
                    (fifo_count <= FIFO_CW'(FIFO_DEPTH - 2));
                if (bit_valid_raw && dec_ready_i
                    && (bitcnt_q == '0)) begin
                    state_d = (bytes_left_q == 8'd1) ? DRAIN : LOAD;
                end
            end
            DRAIN: begin
                if ((idle_q == IW'(DRAIN_CYCLES - 1))
                    && fifo_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_raw = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bytes_left_q <= '0;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            idle_q       <= '0;
        end else begin
            if (start_ok) begin
                bytes_left_q <= nbytes_i;
            end
            if (byte_xfer) begin
                shreg_q  <= byte_i;
                bitcnt_q <= BW'(DATA_WIDTH - 1);
            end
            if (consume) begin
                shreg_q  <= shreg_q << 1;
                bitcnt_q <= bitcnt_q - 1'b1;
                idle_q   <= '0;
                if (last_bit) begin
                    bytes_left_q <= bytes_left_q - 1'b1;
                end
            end
            if (state_q == DRAIN) begin
                if (dec_valid_i) begin
                    idle_q <= '0;
                end else if (idle_q != IW'(DRAIN_CYCLES - 1)) begin
                    idle_q <= idle_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                count_q <= dec_valid_i ? COUNT_WIDTH'(1) : '0;
                ovf_q   <= 1'b0;
            end else if (dec_valid_i) begin
                count_q <= sat_inc(count_q);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    huffman_sym_fifo #(
        .WIDTH (SYM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (dec_valid_i),
        .data_i  (dec_symbol_i),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // outputs are forced low while reset is held, even mid-job
    assign byte_ready_o    = ready_raw && !rst_i;
    assign dec_bit_valid_o = bit_valid_raw && !rst_i;
    assign dec_serial_o    = (state_q == SHIFT) && !rst_i
                             && shreg_q[DATA_WIDTH-1];
    assign sym_valid_o     = !fifo_empty && !rst_i;
    assign sym_o           = sym_valid_o ? fifo_head : '0;
    assign busy_o          = (state_q != IDLE) && !rst_i;
    assign done_o          = done_raw && !rst_i;
    assign sym_count_o     = rst_i ? '0 : count_q;
    assign overflow_o      = ovf_q && !rst_i;

endmodule
